alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU for the risc_cpu datapath. Successor to the 8-op accumulator ALU:

---
 rtl/alu_mc.sv | 145 ++++++++++++++
 tb/tb_alu_mc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU for the risc_cpu datapath.
// Single-cycle ops complete on the accepting edge. MUL runs an iterative
// shift-add over WIDTH cycles.
// Ports:
//   alu_clk, rst_n        clock, async active-low reset
//   in_valid / in_ready   request handshake (in_ready=1 when idle)
//   opcode, data, accum   operation select and operands
//   alu_out, out_valid    registered result and single-cycle completion pulse
//   acc_zero              combinational accum==0 (SKZ test)
//   zero_flag, carry_flag registered result flags
//   op_err                registered reserved-opcode indication
module alu_mc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             alu_clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] accum,
  output logic [WIDTH-1:0] alu_out,
  output logic             out_valid,
  output logic             acc_zero,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             op_err
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    prod, mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  logic [PW-1:0]    prod_acc_c;
  logic [WIDTH:0]   sum_c, diff_c;
  logic             load_c, mul_start_c, mul_step_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c, err_c;

  assign in_ready = (state == S_IDLE);
  assign acc_zero = ~|accum;

  // Extra top bit of sum/diff carries the carry-out / borrow.
  assign sum_c      = {1'b0, accum} + {1'b0, data};
  assign diff_c     = {1'b0, accum} - {1'b0, data};
  assign prod_acc_c = mplier[0] ? (prod + mcand) : prod;

  // State register.
  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, result select and datapath control.
  always_comb begin
    state_nxt   = state;
    load_c      = 1'b0;
    mul_start_c = 1'b0;
    mul_step_c  = 1'b0;
    res_c       = accum;
    carry_c     = 1'b0;
    err_c       = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (opcode == 4'hC) begin
            mul_start_c = 1'b1;
            state_nxt   = S_MUL;
          end else begin
            load_c = 1'b1;
            case (opcode)
              4'h0, 4'h1, 4'h6, 4'h7: res_c = accum;
              4'h2: begin res_c = sum_c[WIDTH-1:0];  carry_c = sum_c[WIDTH];  end
              4'h3: res_c = accum & data;
              4'h4: res_c = accum ^ data;
              4'h5: res_c = data;
              4'h8: begin res_c = diff_c[WIDTH-1:0]; carry_c = diff_c[WIDTH]; end
              4'h9: res_c = accum | data;
              4'hA: begin res_c = {accum[WIDTH-2:0], 1'b0}; carry_c = accum[WIDTH-1]; end
              4'hB: begin res_c = {1'b0, accum[WIDTH-1:1]}; carry_c = accum[0];       end
              default: begin res_c = accum; err_c = 1'b1; end
            endcase
          end
        end
      end
      S_MUL: begin
        mul_step_c = 1'b1;
        // Last iteration: the updated partial product is the final product.
        if (cnt == CNT_W'(WIDTH - 1)) begin
          load_c    = 1'b1;
          res_c     = prod_acc_c[WIDTH-1:0];
          carry_c   = |prod_acc_c[PW-1:WIDTH];
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (mul_start_c) begin
      prod   <= '0;
      mcand  <= PW'(accum);
      mplier <= data;
      cnt    <= '0;
    end else if (mul_step_c) begin
      prod   <= prod_acc_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result and flag registers; hold between completions.
  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out    <= '0;
      out_valid  <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      op_err     <= 1'b0;
    end else begin
      out_valid <= load_c;
      if (load_c) begin
        alu_out    <= res_c;
        zero_flag  <= ~|res_c;
        carry_flag <= carry_c;
        op_err     <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (WIDTH=8) with hand-computed expected values.
module tb_alu_mc;

  logic       alu_clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] data;
  logic [7:0] accum;
  logic [7:0] alu_out;
  logic       out_valid;
  logic       acc_zero;
  logic       zero_flag;
  logic       carry_flag;
  logic       op_err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mc #(.WIDTH(8), .CNT_W(4)) dut (
    .alu_clk    (alu_clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .data       (data),
    .accum      (accum),
    .alu_out    (alu_out),
    .out_valid  (out_valid),
    .acc_zero   (acc_zero),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .op_err     (op_err)
  );

  initial alu_clk = 1'b0;
  always #5 alu_clk = ~alu_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single-cycle op: drive at negedge, check result one cycle later, then pulse end.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] e_res, input logic e_c,
                       input logic e_z, input logic e_err);
    @(negedge alu_clk);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; opcode = op; accum = a; data = d;
    @(negedge alu_clk);
    in_valid = 1'b0;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".res"},   32'(alu_out),   32'(e_res));
    chk({tag, ".carry"}, 32'(carry_flag), 32'(e_c));
    chk({tag, ".zero"},  32'(zero_flag), 32'(e_z));
    chk({tag, ".err"},   32'(op_err),    32'(e_err));
    @(negedge alu_clk);
    chk({tag, ".pulse"}, 32'(out_valid), 32'd0);
    chk({tag, ".hold"},  32'(alu_out),   32'(e_res));
  endtask

  // MUL: busy for 8 cycles with garbage stimulus, result in the 9th cycle.
  task automatic do_mul(input string tag, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] e_res, input logic e_c, input logic e_z);
    @(negedge alu_clk);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; opcode = 4'hC; accum = a; data = d;
    for (int k = 1; k <= 8; k++) begin
      @(negedge alu_clk);
      chk({tag, ".busy"},   32'(in_ready),  32'd0);
      chk({tag, ".novld"},  32'(out_valid), 32'd0);
      in_valid = (k[0] == 1'b1);
      opcode   = 4'h2;
      accum    = 8'(k * 37);
      data     = 8'(k * 91);
    end
    in_valid = 1'b0;
    @(negedge alu_clk);
    chk({tag, ".valid"}, 32'(out_valid),  32'd1);
    chk({tag, ".res"},   32'(alu_out),    32'(e_res));
    chk({tag, ".carry"}, 32'(carry_flag), 32'(e_c));
    chk({tag, ".zero"},  32'(zero_flag),  32'(e_z));
    chk({tag, ".err"},   32'(op_err),     32'd0);
    chk({tag, ".idle"},  32'(in_ready),   32'd1);
    @(negedge alu_clk);
    chk({tag, ".pulse"}, 32'(out_valid),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = 4'h0; data = 8'h00; accum = 8'h00;
    repeat (2) @(negedge alu_clk);
    chk("rst.out",   32'(alu_out),    32'd0);
    chk("rst.valid", 32'(out_valid),  32'd0);
    chk("rst.zero",  32'(zero_flag),  32'd0);
    chk("rst.carry", 32'(carry_flag), 32'd0);
    chk("rst.err",   32'(op_err),     32'd0);
    rst_n = 1'b1;
    @(negedge alu_clk);
    chk("rst.ready", 32'(in_ready), 32'd1);

    do_op("add", 4'h2, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a MUL aborts it.
    @(negedge alu_clk);
    in_valid = 1'b1; opcode = 4'hC; accum = 8'h0C; data = 8'h0B;
    @(negedge alu_clk);
    in_valid = 1'b0;
    repeat (2) @(negedge alu_clk);
    chk("mrst.busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst.out",   32'(alu_out),    32'd0);
    chk("mrst.carry", 32'(carry_flag), 32'd0);
    chk("mrst.valid", 32'(out_valid),  32'd0);
    @(negedge alu_clk);
    rst_n = 1'b1;
    @(negedge alu_clk);
    chk("mrst.ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge alu_clk);
      chk("mrst.quiet", 32'(out_valid), 32'd0);
    end

    do_op("sub_eq", 4'h8, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0);
    do_op("sub_bw", 4'h8, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    do_mul("mul_c_b",  8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0);
    do_mul("mul_ovf",  8'h10, 8'h10, 8'h00, 1'b1, 1'b1);
    do_mul("mul_ff",   8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);
    do_op("shl",  4'hA, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    do_op("shr",  4'hB, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0);
    do_op("and",  4'h3, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b0);
    do_op("xor",  4'h4, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0);
    do_op("or",   4'h9, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0);
    do_op("hlt",  4'h0, 8'h3C, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0);
    do_op("jmp",  4'h7, 8'h00, 8'h77, 8'h00, 1'b0, 1'b1, 1'b0);
    do_op("rsvd", 4'hE, 8'h5A, 8'h11, 8'h5A, 1'b0, 1'b0, 1'b1);
    do_op("lda",  4'h5, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Back-to-back issue on consecutive edges.
    @(negedge alu_clk);
    in_valid = 1'b1; opcode = 4'h2; accum = 8'h01; data = 8'h02;
    @(negedge alu_clk);
    chk("b2b.v1",   32'(out_valid), 32'd1);
    chk("b2b.r1",   32'(alu_out),   32'h03);
    chk("b2b.rdy",  32'(in_ready),  32'd1);
    opcode = 4'h4; accum = 8'hF0; data = 8'h0F;
    @(negedge alu_clk);
    in_valid = 1'b0;
    chk("b2b.v2",   32'(out_valid), 32'd1);
    chk("b2b.r2",   32'(alu_out),   32'hFF);

    // acc_zero follows accum combinationally.
    accum = 8'h00; #1;
    chk("accz.1", 32'(acc_zero), 32'd1);
    accum = 8'h40; #1;
    chk("accz.0", 32'(acc_zero), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
